seg_scan_decoder: RTL

Receive-side counterpart of the four-digit multiplexed seven-segment driver: samples the time-multiplexed active-low `an`/`seg` bus, waits for each digit to settle, decodes the segment pattern back to a 4-bit hex code per digit, and publishes a frame only after it has repeated identically for a set number of scans. It sits in loopback and self-check paths next to the display driver, and on board-level monitors observing the display pins.

---
 rtl/seg_decode_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 38 +++
 rtl/seg_scan_decoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_decode_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Segment patterns are active-low gfedcba; frame_t bundles one published frame.
package seg_decode_pkg;

  localparam logic [6:0] PAT_0 = 7'h40;
  localparam logic [6:0] PAT_1 = 7'h79;
  localparam logic [6:0] PAT_2 = 7'h24;
  localparam logic [6:0] PAT_3 = 7'h30;
  localparam logic [6:0] PAT_4 = 7'h19;
  localparam logic [6:0] PAT_5 = 7'h12;
  localparam logic [6:0] PAT_6 = 7'h02;
  localparam logic [6:0] PAT_7 = 7'h78;
  localparam logic [6:0] PAT_8 = 7'h00;
  localparam logic [6:0] PAT_9 = 7'h10;
  localparam logic [6:0] PAT_A = 7'h08;
  localparam logic [6:0] PAT_B = 7'h03;
  localparam logic [6:0] PAT_C = 7'h46;
  localparam logic [6:0] PAT_D = 7'h21;
  localparam logic [6:0] PAT_E = 7'h06;
  localparam logic [6:0] PAT_F = 7'h0E;

  localparam logic [6:0] BLANK_PAT = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to hex code decoder.
// Ports: pat_i (active-low gfedcba), code_o, blank_o (all off), err_o (unknown).
module seg7_pattern_decode
  import seg_decode_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] code_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    code_o  = 4'h0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (pat_i)
      PAT_0:     code_o = 4'h0;
      PAT_1:     code_o = 4'h1;
      PAT_2:     code_o = 4'h2;
      PAT_3:     code_o = 4'h3;
      PAT_4:     code_o = 4'h4;
      PAT_5:     code_o = 4'h5;
      PAT_6:     code_o = 4'h6;
      PAT_7:     code_o = 4'h7;
      PAT_8:     code_o = 4'h8;
      PAT_9:     code_o = 4'h9;
      PAT_A:     code_o = 4'hA;
      PAT_B:     code_o = 4'hB;
      PAT_C:     code_o = 4'hC;
      PAT_D:     code_o = 4'hD;
      PAT_E:     code_o = 4'hE;
      PAT_F:     code_o = 4'hF;
      BLANK_PAT: blank_o = 1'b1;
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low an/seg display bus and publishes stable frames.
// Ports: clk, rst_n (sync low), an[3:0], seg[6:0] in; digits[15:0], blank[3:0],
// pat_err[3:0], valid, update, ghost, stall out. Macro SEG_DECODE_TIMEOUT_EN
// compiles in the scan-stall watchdog; otherwise stall is constant 0.
module seg_scan_decoder
  import seg_decode_pkg::*;
#(
  parameter int SETTLE_CYC   = 16,
  parameter int MATCH_FRAMES = 2,
  parameter int TIMEOUT_CYC  = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  pat_err,
  output logic        valid,
  output logic        update,
  output logic        ghost,
  output logic        stall
);

  localparam int CW = $clog2(SETTLE_CYC);
  localparam int MW = $clog2(MATCH_FRAMES + 1);

  // Two-flop synchronizers plus a one-cycle history for change detection.
  logic [3:0] an_s1_q, an_s_q, an_l_q;
  logic [6:0] seg_s1_q, seg_s_q, seg_l_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_s1_q  <= 4'hF;
      an_s_q   <= 4'hF;
      an_l_q   <= 4'hF;
      seg_s1_q <= BLANK_PAT;
      seg_s_q  <= BLANK_PAT;
      seg_l_q  <= BLANK_PAT;
    end else begin
      an_s1_q  <= an;
      an_s_q   <= an_s1_q;
      an_l_q   <= an_s_q;
      seg_s1_q <= seg;
      seg_s_q  <= seg_s1_q;
      seg_l_q  <= seg_s_q;
    end
  end

  logic       an_chg, seg_chg, gap, multi, multi_l;
  logic [3:0] lo, lo_l;

  assign an_chg  = an_s_q != an_l_q;
  assign seg_chg = seg_s_q != seg_l_q;
  assign gap     = an_s_q == 4'hF;
  assign lo      = ~an_s_q;
  assign lo_l    = ~an_l_q;
  // x & (x-1) is nonzero when two or more bits are set.
  assign multi   = |(lo & (lo - 4'd1));
  assign multi_l = |(lo_l & (lo_l - 4'd1));

  logic timeout_hit;
  logic wd_stop;

`ifdef SEG_DECODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q;
  logic          stall_q;

  assign timeout_hit = !stall_q && !an_chg &&
                       (wd_q == TW'(TIMEOUT_CYC - 1));
  assign wd_stop     = timeout_hit || stall_q;
  assign stall       = stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else if (an_chg) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else if (timeout_hit) begin
      stall_q <= 1'b1;
    end else if (!stall_q) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign wd_stop     = 1'b0;
  // Constant-false expression; keeps the parameter referenced.
  assign stall       = (TIMEOUT_CYC < 0);
`endif

  // FSM: state register.
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort;

  assign abort = gap || multi || wd_stop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. Gaps, ghosts and stalls override every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (an_chg || seg_chg) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CAPTURE: state_d = ST_HOLD;
        ST_HOLD: begin
          if (an_chg) begin
            state_d = ST_IDLE;
          end else if (seg_chg) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs. Capture uses the last settled values (an_l_q/seg_l_q).
  logic cap_en;

  always_comb begin
    cap_en = (state_q == ST_CAPTURE) && !abort;
  end

  logic [3:0] dec_code;
  logic       dec_blank, dec_err;

  seg7_pattern_decode u_dec (
    .pat_i   (seg_l_q),
    .code_o  (dec_code),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  frame_t        shadow_q, shadow_d, prev_q, out_q;
  logic [3:0]    mask_q, mask_new, sel;
  logic [MW-1:0] match_q, match_nx;
  logic          complete, publish;
  logic          valid_q, upd_q, ghost_q;

  assign sel = ~an_l_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        shadow_d.digits[4*i +: 4] = dec_code;
        shadow_d.blank[i]         = dec_blank;
        shadow_d.err[i]           = dec_err;
      end
    end
    mask_new = mask_q | sel;
    complete = cap_en && (mask_new == 4'hF);
    if (shadow_d != prev_q) begin
      match_nx = MW'(1);
    end else if (match_q == MW'(MATCH_FRAMES)) begin
      match_nx = match_q;
    end else begin
      match_nx = match_q + 1'b1;
    end
    publish = complete && (match_nx == MW'(MATCH_FRAMES));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      mask_q   <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
      ghost_q  <= 1'b0;
    end else begin
      upd_q   <= 1'b0;
      ghost_q <= multi && !multi_l;
      if (timeout_hit) begin
        mask_q  <= '0;
        match_q <= '0;
        valid_q <= 1'b0;
      end else if (cap_en) begin
        shadow_q <= shadow_d;
        if (complete) begin
          mask_q  <= '0;
          prev_q  <= shadow_d;
          match_q <= match_nx;
          if (publish) begin
            out_q   <= shadow_d;
            valid_q <= 1'b1;
            upd_q   <= (shadow_d != out_q) || !valid_q;
          end
        end else begin
          mask_q <= mask_new;
        end
      end
    end
  end

  assign digits  = out_q.digits;
  assign blank   = out_q.blank;
  assign pat_err = out_q.err;
  assign valid   = valid_q;
  assign update  = upd_q;
  assign ghost   = ghost_q;

endmodule
